// File: rtl/rc4_stream_core.sv
// rc4_stream_core: RC4 engine; fills an external 256x8 S-box, runs KSA, then XORs the din stream with keystream (RC4_DROP_EN adds RC4-drop[DROP_N]).
// Latency: start to first din_ready is 1029 cycles (+4*DROP_N with drop); 5 cycles per byte when both sides are free-flowing.
// Backpressure: din_ready only while the output register is empty or being drained; dout holds while dout_ready is low.
module rc4_stream_core #(
  parameter int KEY_BYTES = 16,
  parameter int LEN_W     = 16,
  parameter int DROP_N    = 768
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key_in,
  input  logic [5:0]             key_len,
  input  logic [LEN_W-1:0]       msg_len,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [7:0]             din,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [7:0]             dout,
  output logic                   busy,
  output logic                   done,
  output logic                   sbox_rd,
  output logic                   sbox_wr,
  output logic [7:0]             sbox_raddr,
  output logic [7:0]             sbox_waddr,
  output logic [7:0]             sbox_din,
  input  logic [7:0]             sbox_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_K1, S_K2, S_K3, S_G1, S_G2, S_G3, S_G4, S_XFER, S_DRAIN
  } state_t;

  localparam logic [5:0] KB6 = 6'(KEY_BYTES);

  state_t           st;
  logic [7:0]       i, j, si, sj, ks;
  logic [5:0]       klen, kidx;
  logic [LEN_W-1:0] mlen, cnt;
  logic [7:0]       key_byte, j_next, i_inc;
  logic [LEN_W-1:0] cnt_inc;
  logic             in_fire;
  logic             dropping;

`ifdef RC4_DROP_EN
  localparam int DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  logic [DW-1:0] drop_cnt;
  assign dropping = (drop_cnt != '0);
`else
  logic unused_drop_n;
  assign unused_drop_n = (DROP_N != 0);
  assign dropping      = 1'b0;
`endif

  assign key_byte  = 8'(key_in >> {kidx, 3'b000});
  assign j_next    = j + sbox_dout + ((st == S_K1) ? key_byte : 8'd0);
  assign i_inc     = i + 8'd1;
  assign cnt_inc   = cnt + LEN_W'(1);
  assign din_ready = (st == S_XFER) && (!dout_valid || dout_ready);
  assign in_fire   = din_valid && din_ready;

  // S-box strobes are registered: each state sets up the accesses of the state it moves to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_IDLE;
      i          <= 8'd0;
      j          <= 8'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      ks         <= 8'd0;
      klen       <= 6'd0;
      kidx       <= 6'd0;
      mlen       <= '0;
      cnt        <= '0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sbox_rd    <= 1'b0;
      sbox_wr    <= 1'b0;
      sbox_raddr <= 8'd0;
      sbox_waddr <= 8'd0;
      sbox_din   <= 8'd0;
`ifdef RC4_DROP_EN
      drop_cnt   <= '0;
`endif
    end else begin
      done       <= 1'b0;
      sbox_rd    <= 1'b0;
      sbox_wr    <= 1'b0;
      sbox_raddr <= 8'd0;
      sbox_waddr <= 8'd0;
      sbox_din   <= 8'd0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      unique case (st)
        S_IDLE: begin
          if (start) begin
            klen    <= (key_len == 6'd0 || key_len > KB6) ? KB6 : key_len;
            mlen    <= msg_len;
            i       <= 8'd0;
            j       <= 8'd0;
            kidx    <= 6'd0;
            cnt     <= '0;
            busy    <= 1'b1;
            sbox_wr <= 1'b1;
            st      <= S_INIT;
          end
        end
        S_INIT: begin
          if (i == 8'hFF) begin
            i       <= 8'd0;
            sbox_rd <= 1'b1;
            st      <= S_K1;
          end else begin
            i          <= i_inc;
            sbox_wr    <= 1'b1;
            sbox_waddr <= i_inc;
            sbox_din   <= i_inc;
          end
        end
        S_K1: begin
          si         <= sbox_dout;
          j          <= j_next;
          kidx       <= (kidx == klen - 6'd1) ? 6'd0 : kidx + 6'd1;
          sbox_rd    <= 1'b1;
          sbox_raddr <= j_next;
          sbox_wr    <= 1'b1;
          sbox_waddr <= j_next;
          sbox_din   <= sbox_dout;
          st         <= S_K2;
        end
        S_K2: begin
          sj         <= sbox_dout;
          sbox_wr    <= 1'b1;
          sbox_waddr <= i;
          sbox_din   <= sbox_dout;
          st         <= S_K3;
        end
        S_K3: begin
          sbox_rd <= 1'b1;
          if (i == 8'hFF) begin
            // PRGA starts from i=j=0; its first step increments i, folded in here.
            i          <= 8'd1;
            j          <= 8'd0;
            sbox_raddr <= 8'd1;
            st         <= S_G1;
`ifdef RC4_DROP_EN
            drop_cnt   <= DW'(DROP_N);
`endif
          end else begin
            i          <= i_inc;
            sbox_raddr <= i_inc;
            st         <= S_K1;
          end
        end
        S_G1: begin
          si         <= sbox_dout;
          j          <= j_next;
          sbox_rd    <= 1'b1;
          sbox_raddr <= j_next;
          sbox_wr    <= 1'b1;
          sbox_waddr <= j_next;
          sbox_din   <= sbox_dout;
          st         <= S_G2;
        end
        S_G2: begin
          sj         <= sbox_dout;
          sbox_wr    <= 1'b1;
          sbox_waddr <= i;
          sbox_din   <= sbox_dout;
          st         <= S_G3;
        end
        S_G3: begin
          sbox_rd    <= 1'b1;
          sbox_raddr <= si + sj;
          st         <= S_G4;
        end
        S_G4: begin
          ks <= sbox_dout;
          if (dropping) begin
`ifdef RC4_DROP_EN
            drop_cnt   <= drop_cnt - DW'(1);
`endif
            i          <= i_inc;
            sbox_rd    <= 1'b1;
            sbox_raddr <= i_inc;
            st         <= S_G1;
          end else if (cnt == mlen) begin
            // only reachable with a zero-length message
            done <= 1'b1;
            busy <= 1'b0;
            st   <= S_IDLE;
          end else begin
            st <= S_XFER;
          end
        end
        S_XFER: begin
          if (in_fire) begin
            dout       <= din ^ ks;
            dout_valid <= 1'b1;
            cnt        <= cnt_inc;
            if (cnt_inc == mlen) begin
              st <= S_DRAIN;
            end else begin
              i          <= i_inc;
              sbox_rd    <= 1'b1;
              sbox_raddr <= i_inc;
              st         <= S_G1;
            end
          end
        end
        S_DRAIN: begin
          if (!dout_valid || dout_ready) begin
            done <= 1'b1;
            busy <= 1'b0;
            st   <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// Bench for rc4_stream_core: known-answer and random streams against an array-based RC4 model,
// with a behavioural S-box RAM, handshake backpressure, zero-length, restart and mid-run reset scenarios.
`timescale 1ns/1ps
module tb_rc4_stream_core;
  localparam int KB = 16;
  localparam int LW = 16;
  localparam int DN = 1;
`ifdef RC4_DROP_EN
  localparam int DROPS = DN;
`else
  localparam int DROPS = 0;
`endif
  localparam int LAT = 1029 + 4 * DROPS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [8*KB-1:0] key_in = '0;
  logic [5:0]    key_len = 6'd0;
  logic [LW-1:0] msg_len = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [7:0]    din = 8'd0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [7:0]    dout;
  logic          busy, done;
  logic          sbox_rd, sbox_wr;
  logic [7:0]    sbox_raddr, sbox_waddr, sbox_din, sbox_dout;

  rc4_stream_core #(.KEY_BYTES(KB), .LEN_W(LW), .DROP_N(DN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .key_in(key_in), .key_len(key_len),
    .msg_len(msg_len), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .busy(busy),
    .done(done), .sbox_rd(sbox_rd), .sbox_wr(sbox_wr), .sbox_raddr(sbox_raddr),
    .sbox_waddr(sbox_waddr), .sbox_din(sbox_din), .sbox_dout(sbox_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] sram [256];
  always @(posedge clk) if (sbox_wr) sram[sbox_waddr] <= sbox_din;
  assign sbox_dout = sram[sbox_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] ks_q[$];
  int d_first_rdy, d_dones, d_done_cyc, d_last_out, d_stall_err, d_busy_bad, d_timeout;

  function automatic logic [8*KB-1:0] str_key(input string s);
    logic [8*KB-1:0] k = '0;
    for (int n = 0; n < s.len(); n++) k[8*n +: 8] = s[n];
    return k;
  endfunction

  // Textbook RC4 (optionally drop-N) over a plain integer array.
  task automatic model_ks(input logic [8*KB-1:0] key, input int kl, input int n);
    int s[256];
    int ii, jj, t, len;
    len = (kl == 0 || kl > KB) ? KB : kl;
    for (int k = 0; k < 256; k++) s[k] = k;
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      jj = (jj + s[k] + int'(key[8*(k % len) +: 8])) % 256;
      t = s[k]; s[k] = s[jj]; s[jj] = t;
    end
    ii = 0; jj = 0;
    ks_q.delete();
    for (int k = 0; k < DROPS + n; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      if (k >= DROPS) ks_q.push_back(8'(s[(s[ii] + s[jj]) % 256]));
    end
  endtask

  task automatic drive_msg(input logic [8*KB-1:0] key, input logic [5:0] kl, input int n,
                           input bit bp, input int restart_at);
    int t0, c, k, budget;
    bit stalled, acc;
    logic [7:0] held;
    rx_q.delete();
    d_first_rdy = -1; d_dones = 0; d_done_cyc = -1; d_last_out = -1;
    d_stall_err = 0; d_busy_bad = 0; d_timeout = 0;
    k = 0; stalled = 1'b0; acc = 1'b0; held = 8'd0;
    budget = LAT + 40 * n + 100;
    @(negedge clk);
    key_in = key; key_len = kl; msg_len = LW'(n);
    din_valid = 1'b0; dout_ready = 1'b0; start = 1'b1;
    t0 = cyc;
    forever begin
      @(negedge clk);
      c = cyc - t0;
      start = (c == restart_at);
      if (acc) din_valid = 1'b0;
      if (!din_valid && k < n && (!bp || $urandom_range(0, 2) != 0)) begin
        din_valid = 1'b1;
        din = tx_q[k];
      end
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled && (dout_valid !== 1'b1 || dout !== held)) d_stall_err++;
      if (din_ready === 1'b1 && d_first_rdy < 0) begin
        d_first_rdy = c;
        if (busy !== 1'b1) d_busy_bad++;
      end
      if (done === 1'b1) begin
        d_dones++;
        if (d_done_cyc < 0) d_done_cyc = c;
        if (busy !== 1'b0) d_busy_bad++;
      end
      if (dout_valid === 1'b1 && dout_ready) begin
        rx_q.push_back(dout);
        d_last_out = c;
      end
      stalled = (dout_valid === 1'b1) && !dout_ready;
      held = dout;
      acc = din_valid && (din_ready === 1'b1);
      if (acc) k++;
      if (d_done_cyc >= 0 && c >= d_done_cyc + 3) break;
      if (c > budget) begin
        d_timeout = 1;
        break;
      end
    end
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %b exp 0", din_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", dout_valid); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
    checks++; if ({sbox_rd, sbox_wr} !== 2'b00) begin errors++; $display("FAIL reset_sbox_strobes got %b exp 00", {sbox_rd, sbox_wr}); end
    checks++; if ({sbox_raddr, sbox_waddr, sbox_din} !== 24'h0) begin errors++; $display("FAIL reset_sbox_bus got %h exp 0", {sbox_raddr, sbox_waddr, sbox_din}); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vectors(input bit bp);
    string keys[3];
    string pts[3];
    string kk, pp;
    logic [7:0] ct[$];
    logic [7:0] exp_b;
    int off;
    keys = '{"Key", "Wiki", "Secret"};
    pts  = '{"Plaintext", "pedia", "Attack at dawn"};
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3,
           8'h10, 8'h21, 8'hBF, 8'h04, 8'h20,
           8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    off = 0;
    for (int v = 0; v < 3; v++) begin
      kk = keys[v]; pp = pts[v];
      tx_q.delete();
      for (int b = 0; b < pp.len(); b++) tx_q.push_back(pp[b]);
      model_ks(str_key(kk), kk.len(), pp.len());
      drive_msg(str_key(kk), 6'(kk.len()), pp.len(), bp, -1);
      checks++; if (d_timeout != 0) begin errors++; $display("FAIL kv%0d_timeout bp=%0d got timeout exp done", v, bp); end
      checks++; if (d_first_rdy != LAT) begin errors++; $display("FAIL kv%0d_latency got %0d exp %0d", v, d_first_rdy, LAT); end
      checks++; if (d_dones != 1) begin errors++; $display("FAIL kv%0d_done_count got %0d exp 1", v, d_dones); end
      checks++; if (rx_q.size() != pp.len()) begin errors++; $display("FAIL kv%0d_byte_count got %0d exp %0d", v, rx_q.size(), pp.len()); end
      checks++; if (d_done_cyc != d_last_out + 1) begin errors++; $display("FAIL kv%0d_done_timing got %0d exp %0d", v, d_done_cyc, d_last_out + 1); end
      checks++; if (d_stall_err != 0 || d_busy_bad != 0) begin errors++; $display("FAIL kv%0d_stall_busy got %0d/%0d exp 0/0", v, d_stall_err, d_busy_bad); end
      for (int b = 0; b < pp.len() && b < rx_q.size(); b++) begin
`ifdef RC4_DROP_EN
        exp_b = tx_q[b] ^ ks_q[b];
`else
        exp_b = ct[off + b];
`endif
        checks++;
        if (rx_q[b] !== exp_b) begin errors++; $display("FAIL kv%0d_byte%0d bp=%0d got %h exp %h", v, b, bp, rx_q[b], exp_b); end
      end
      off += pp.len();
    end
  endtask

  task automatic test_random();
    logic [8*KB-1:0] key;
    int kl, n;
    bit bp;
    for (int it = 0; it < 4; it++) begin
      for (int b = 0; b < KB; b++) key[8*b +: 8] = 8'($urandom);
      kl = $urandom_range(0, 40);
      n  = $urandom_range(1, 10);
      bp = 1'($urandom_range(0, 1));
      tx_q.delete();
      for (int b = 0; b < n; b++) tx_q.push_back(8'($urandom));
      model_ks(key, kl, n);
      drive_msg(key, 6'(kl), n, bp, -1);
      checks++; if (d_timeout != 0 || d_dones != 1) begin errors++; $display("FAIL rnd%0d_completion got timeout=%0d dones=%0d exp 0/1", it, d_timeout, d_dones); end
      checks++; if (rx_q.size() != n) begin errors++; $display("FAIL rnd%0d_byte_count got %0d exp %0d", it, rx_q.size(), n); end
      checks++; if (d_stall_err != 0) begin errors++; $display("FAIL rnd%0d_dout_stable got %0d exp 0", it, d_stall_err); end
      for (int b = 0; b < n && b < rx_q.size(); b++) begin
        checks++;
        if (rx_q[b] !== (tx_q[b] ^ ks_q[b])) begin
          errors++; $display("FAIL rnd%0d_byte%0d kl=%0d got %h exp %h", it, b, kl, rx_q[b], tx_q[b] ^ ks_q[b]);
        end
      end
    end
  endtask

  task automatic test_zero_len_and_restart();
    tx_q.delete();
    drive_msg(str_key("Key"), 6'd3, 0, 1'b0, 500);
    checks++; if (d_first_rdy != -1) begin errors++; $display("FAIL zero_din_ready got first at %0d exp never", d_first_rdy); end
    checks++; if (d_done_cyc != LAT) begin errors++; $display("FAIL zero_done_cycle got %0d exp %0d", d_done_cyc, LAT); end
    checks++; if (d_dones != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", d_dones); end
    checks++; if (rx_q.size() != 0 || d_busy_bad != 0) begin errors++; $display("FAIL zero_traffic got bytes=%0d busybad=%0d exp 0/0", rx_q.size(), d_busy_bad); end
  endtask

  task automatic test_reset_mid_gen();
    string pp;
    pp = "Plaintext";
    model_ks(str_key("Key"), 3, 9);
    @(negedge clk);
    key_in = str_key("Key"); key_len = 6'd3; msg_len = LW'(9);
    din_valid = 1'b1; din = pp[0]; dout_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #1;
    checks++; if (sbox_wr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_gen got wr=%b busy=%b exp 1/1", sbox_wr, busy); end
    checks++; if (dout_valid !== 1'b1 || dout !== (pp[0] ^ ks_q[0])) begin errors++; $display("FAIL midrst_pre_dout got %b/%h exp 1/%h", dout_valid, dout, pp[0] ^ ks_q[0]); end
    rstn = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, dout_valid, din_ready, sbox_rd, sbox_wr} !== 6'b0 || {dout, sbox_raddr, sbox_waddr, sbox_din} !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs got %b/%h exp 0/0", {busy, done, dout_valid, din_ready, sbox_rd, sbox_wr}, {dout, sbox_raddr, sbox_waddr, sbox_din});
    end
    rstn = 1'b1;
    @(negedge clk);
    tx_q.delete();
    for (int b = 0; b < pp.len(); b++) tx_q.push_back(pp[b]);
    drive_msg(str_key("Key"), 6'd3, 9, 1'b0, -1);
    checks++; if (d_timeout != 0 || d_dones != 1 || rx_q.size() != 9) begin errors++; $display("FAIL midrst_rerun got timeout=%0d dones=%0d bytes=%0d exp 0/1/9", d_timeout, d_dones, rx_q.size()); end
    for (int b = 0; b < 9 && b < rx_q.size(); b++) begin
      checks++;
      if (rx_q[b] !== (tx_q[b] ^ ks_q[b])) begin errors++; $display("FAIL midrst_byte%0d got %h exp %h", b, rx_q[b], tx_q[b] ^ ks_q[b]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors(1'b0);
    test_known_vectors(1'b1);
    test_random();
    test_zero_len_and_restart();
    test_reset_mid_gen();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
